// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and ASCII constants.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_e;

  localparam logic [BYTE_W-1:0] ASCII_CR  = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF  = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_ESC = 8'h1B;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with registered occupancy count; the full test uses the count at the start of the cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [BYTE_W-1:0]     push_data,
  input  logic                  pop,
  output logic [BYTE_W-1:0]     head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

  logic [BYTE_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy separately.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers lab-DUT tx bytes and hands them to buart one strobe at a time, paced by busy.
// Optional CRLF_EXPAND_EN: a popped LF is sent as CR followed by LF.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned BUSY_TO    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     txdata,
  input  logic                  txDataValid,
  input  logic                  txBusy,
  output logic [BYTE_W-1:0]     utb_txdata,
  output logic                  utb_txdata_rdy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int unsigned TMR_W = $clog2(BUSY_TO + 1);

  tx_state_e         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [BYTE_W-1:0] data_d;
  logic              rdy_d;
  logic              pop;
  logic [BYTE_W-1:0] head;
  logic              full;
  logic              empty;
`ifdef CRLF_EXPAND_EN
  logic              pend_q, pend_d;
`endif

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (txDataValid),
    .push_data (txdata),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      utb_txdata     <= '0;
      utb_txdata_rdy <= 1'b0;
      overflow       <= 1'b0;
`ifdef CRLF_EXPAND_EN
      pend_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      utb_txdata     <= data_d;
      utb_txdata_rdy <= rdy_d;
      overflow       <= overflow | (txDataValid & full);
`ifdef CRLF_EXPAND_EN
      pend_q         <= pend_d;
`endif
    end
  end

  // Timeout counts from the strobe cycle, so the ISSUE cycle is the first of BUSY_TO.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = utb_txdata;
    rdy_d   = 1'b0;
    pop     = 1'b0;
`ifdef CRLF_EXPAND_EN
    pend_d  = pend_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef CRLF_EXPAND_EN
        if (pend_q && !txBusy) begin
          data_d  = ASCII_LF;
          pend_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = ISSUE;
        end else if (!empty && !txBusy) begin
          pop     = 1'b1;
          rdy_d   = 1'b1;
          state_d = ISSUE;
          if (head == ASCII_LF) begin
            data_d = ASCII_CR;
            pend_d = 1'b1;
          end else begin
            data_d = head;
          end
        end
`else
        if (!empty && !txBusy) begin
          pop     = 1'b1;
          data_d  = head;
          rdy_d   = 1'b1;
          state_d = ISSUE;
        end
`endif
      end
      ISSUE: begin
        timer_d = TMR_W'(1);
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (txBusy) begin
          state_d = WAIT_LO;
        end else if (timer_q >= TMR_W'(BUSY_TO - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_LO: begin
        if (!txBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a monitor checks each strobe.
module tb_uart_tx_fifo;

  localparam int unsigned DL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    txdata = 8'h00;
  logic          txDataValid = 1'b0;
  logic          txBusy = 1'b0;
  logic [7:0]    utb_txdata;
  logic          utb_txdata_rdy;
  logic [DL:0]   fifo_count;
  logic          overflow;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         strobes = 0;
  int         strobe_cyc[$];
  logic [7:0] exp_q[$];
  int         busy_mode = 0;   // 0: model, 1: forced high, 2: tied low
  int         busy_hold = 10;
  int         busy_cnt = 0;
  int         peak = 0;

  uart_tx_fifo #(.DEPTH_LOG2(DL), .BUSY_TO(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .txdata         (txdata),
    .txDataValid    (txDataValid),
    .txBusy         (txBusy),
    .utb_txdata     (utb_txdata),
    .utb_txdata_rdy (utb_txdata_rdy),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Busy model: rises right after a strobe and holds busy_hold cycles.
  initial begin
    forever begin
      @(negedge clk);
      case (busy_mode)
        1: txBusy = 1'b1;
        2: txBusy = 1'b0;
        default: begin
          if (utb_txdata_rdy) busy_cnt = busy_hold;
          else if (busy_cnt > 0) busy_cnt--;
          txBusy = (busy_cnt > 0);
        end
      endcase
    end
  end

  // Monitor: every strobe must match the head of the expected queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && int'(fifo_count) > peak) peak = int'(fifo_count);
      if (utb_txdata_rdy) begin
        strobes++;
        strobe_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got byte 0x%0h expected no strobe at cycle %0d", utb_txdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if (utb_txdata != e) begin
            errors++;
            $display("FAIL strobe_data: got 0x%0h expected 0x%0h at cycle %0d", utb_txdata, e, cyc);
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_out);
    @(posedge clk);
    #1;
    txDataValid = 1'b1;
    txdata      = b;
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic push_end();
    @(posedge clk);
    #1;
    txDataValid = 1'b0;
  endtask

  task automatic wait_strobes(input string name, input int target, input int budget);
    int n = 0;
    while (strobes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, strobes, target);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    txDataValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    busy_cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    int s0;
    int pc;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_rdy", int'(utb_txdata_rdy), 0);
      check("reset_count", int'(fifo_count), 0);
      check("reset_overflow", int'(overflow), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_rdy", int'(utb_txdata_rdy), 0);

    // Single byte, latency N+2, no repeat strobe
    busy_mode = 0;
    busy_hold = 10;
    s0 = strobes;
    push_byte(8'h41, 1'b1);
    pc = cyc;
    push_end();
    wait_strobes("single_strobe", s0 + 1, 50);
    check("single_latency", strobe_cyc[s0] - pc, 2);
    repeat (30) @(negedge clk);
    check("single_no_repeat", strobes, s0 + 1);

    // Burst 0x30..0x3F with long busy windows
    busy_hold = 20;
    peak = 0;
    s0 = strobes;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i), 1'b1);
    push_end();
    wait_strobes("burst_strobes", s0 + 16, 800);
    check("burst_peak", peak, 15);
    check("burst_overflow", int'(overflow), 0);
    check("burst_drained", exp_q.size(), 0);
    repeat (30) @(negedge clk);

    // Overflow with busy held high
    busy_hold = 10;
    busy_mode = 1;
    @(negedge clk);
    s0 = strobes;
    for (int i = 0; i < 17; i++) push_byte(8'(8'h70 + i), i < 16);
    push_end();
    @(negedge clk);
    check("ovf_count", int'(fifo_count), 16);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_no_strobe", strobes, s0);
    busy_cnt = 0;
    busy_mode = 0;
    wait_strobes("ovf_drain", s0 + 16, 600);
    repeat (30) @(negedge clk);
    check("ovf_17th_absent", strobes, s0 + 16);
    check("ovf_sticky", int'(overflow), 1);

    // Busy timeout with busy tied low
    do_reset();
    @(negedge clk);
    check("reset_clears_ovf", int'(overflow), 0);
    busy_mode = 2;
    s0 = strobes;
    push_byte(8'h55, 1'b1);
    pc = cyc;
    push_byte(8'h66, 1'b1);
    push_end();
    wait_strobes("timeout_strobes", s0 + 2, 60);
    check("timeout_latency", strobe_cyc[s0] - pc, 2);
    check("timeout_spacing", strobe_cyc[s0 + 1] - strobe_cyc[s0], 5);
    repeat (20) @(negedge clk);

    // LF handling
    busy_mode = 0;
    s0 = strobes;
`ifdef CRLF_EXPAND_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    push_byte(8'h0A, 1'b0);
    push_end();
    wait_strobes("lf_strobes", s0 + 2, 100);
    repeat (30) @(negedge clk);
    check("lf_strobe_total", strobes, s0 + 2);
`else
    push_byte(8'h0A, 1'b1);
    push_end();
    wait_strobes("lf_strobes", s0 + 1, 100);
    repeat (30) @(negedge clk);
    check("lf_strobe_total", strobes, s0 + 1);
`endif

    // Reset during WAIT_LO with five bytes queued
    s0 = strobes;
    for (int i = 0; i < 6; i++) push_byte(8'(8'hA0 + i), i == 0);
    push_end();
    wait_strobes("midrst_first", s0 + 1, 20);
    @(negedge clk);
    check("midrst_queued", int'(fifo_count), 5);
    do_reset();
    @(negedge clk);
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_rdy", int'(utb_txdata_rdy), 0);
    repeat (40) @(negedge clk);
    check("midrst_no_strobe", strobes, s0 + 1);
    check("midrst_count_idle", int'(fifo_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
